// File: rtl/imem_loader.sv
// Instruction memory loader: fills a DEPTH x 32 store from a
// valid/ready word stream and serves registered reads to the CPU.
`timescale 1ns/1ps
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [9:0]    PCaddr,
  output logic [31:0]   instruction,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          overflow_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [AW:0] LP_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] LP_ONE  = (AW+1)'(1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_cnt;
  logic [AW:0] w_cnt_nxt;
  logic        r_ovf;
  logic        w_ovf_nxt;
  logic        w_xfer;
  logic        w_full;
  logic        w_in_range;
  logic [31:0] r_instr;

  assign w_full       = (r_cnt == LP_LAST);
  assign w_in_range   = (PCaddr[9:AW] == '0);
  assign word_count   = r_cnt;
  assign overflow_err = r_ovf;
  assign instruction  = r_instr;

  // Next-state, counter/flag update and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_xfer    = 1'b0;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_LOAD;
          w_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        w_xfer   = in_valid;
        if (in_valid) begin
          w_cnt_nxt = r_cnt + LP_ONE;
          if (in_last) begin
            w_next = S_DONE;
          end else if (w_full) begin
            w_next    = S_DONE;
            w_ovf_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) begin
          w_next    = S_LOAD;
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, word counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Storage write; no reset so contents survive reloads and resets
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[r_cnt[AW-1:0]] <= in_data;
    end
  end

  // Registered read; out-of-range addresses return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
    end else if (w_in_range) begin
      r_instr <= r_mem[PCaddr[AW-1:0]];
    end else begin
      r_instr <= '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard queue of expected
// read data plus immediate-assertion checks of control outputs.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [9:0]  PCaddr;
  logic [31:0] instruction;
  logic        cpu_hold;
  logic        load_done;
  logic [5:0]  word_count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  int          mcnt;
  logic [31:0] q [$];

  imem_loader #(.DEPTH(32), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .PCaddr       (PCaddr),
    .instruction  (instruction),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [9:0] a);
    if (a[9:5] != 5'd0) return 32'h0;
    return mdl[a[4:0]];
  endfunction

  task automatic rd(input string tag, input logic [9:0] a);
    PCaddr = a;
    q.push_back(mread(a));
    tick();
    chk(tag, instruction, q.pop_front());
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mcnt  = 0;
    chk("start_rdy", {31'd0, in_ready}, 32'd1);
    chk("start_cnt", {26'd0, word_count}, 32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("send_rdy", {31'd0, in_ready}, 32'd1);
    mdl[mcnt[4:0]] = d;
    mcnt++;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_done(input string tag, input int cnt,
                          input logic ovf);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_cnt"}, {26'd0, word_count}, cnt);
    chk({tag, "_ovf"}, {31'd0, overflow_err}, {31'd0, ovf});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; PCaddr = '0; mcnt = 0;
    tick(); tick();
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_cnt", {26'd0, word_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_hold", {31'd0, cpu_hold}, 32'd1);
    chk("idle_rdy", {31'd0, in_ready}, 32'd0);

    // Three-word program
    do_start();
    send(32'h20080005, 1'b0);
    send(32'h20090003, 1'b0);
    send(32'h01095020, 1'b1);
    chk_done("p3", 3, 1'b0);
    rd("p3_rd1", 10'd1);
    rd("p3_rd0", 10'd0);
    rd("p3_rd2", 10'd2);
    rd("oor", 10'h020);

    // Gapped stream, start ignored during load
    do_start();
    send(32'hAAAA0001, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gap_cnt", {26'd0, word_count}, 32'd1);
    chk("gap_rdy", {31'd0, in_ready}, 32'd1);
    send(32'hBBBB0002, 1'b1);
    chk_done("gap", 2, 1'b0);
    rd("gap_rd0", 10'd0);
    rd("gap_rd1", 10'd1);
    rd("gap_keep2", 10'd2);

    // Full image, last on final word
    do_start();
    for (int i = 0; i < 32; i++)
      send(32'h1000 + i, i == 31);
    chk_done("full", 32, 1'b0);
    rd("full_rd31", 10'd31);
    rd("full_rd0", 10'd0);

    // Full image, no last: overflow
    do_start();
    for (int i = 0; i < 32; i++) begin
      send(32'h2000 + i, 1'b0);
      if (i == 30) begin
        chk("ovf_pre_cnt", {26'd0, word_count}, 32'd31);
        chk("ovf_pre", {31'd0, overflow_err}, 32'd0);
      end
    end
    chk_done("ovf", 32, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    chk("ovf33_cnt", {26'd0, word_count}, 32'd32);
    rd("ovf33_rd0", 10'd0);
    rd("ovf_rd31", 10'd31);

    // Restart from DONE clears flags; reset mid-load
    do_start();
    chk("rs_ovf", {31'd0, overflow_err}, 32'd0);
    chk("rs_done", {31'd0, load_done}, 32'd0);
    chk("rs_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 5; i++)
      send(32'h3000 + i, 1'b0);
    PCaddr   = 10'd1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    rst = 1'b1;
    #1;
    chk("arst_rdy", {31'd0, in_ready}, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_cnt", {26'd0, word_count}, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick(); tick();
    chk("post_hold", {31'd0, cpu_hold}, 32'd1);
    chk("post_rdy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++)
      rd("arst_keep", 10'(i));

    // Short reload, read-during-write returns old data
    do_start();
    PCaddr = 10'd0;
    q.push_back(mread(10'd0));
    send(32'h4000, 1'b1);
    chk("rdw", instruction, q.pop_front());
    chk_done("short", 1, 1'b0);
    rd("short_rd0", 10'd0);
    for (int i = 1; i < 6; i++)
      rd("short_keep", 10'(i));
    rd("short_keep31", 10'd31);
    rd("short_oor", 10'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
